// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// mul_arbiter
//   Round-robin arbiter that shares one 4x4 multiplier between four
//   requesters. A winner's operands are latched at grant time and presented
//   to the multiplier together with a one-cycle start pulse. The arbiter then
//   waits for the multiplier to go busy and come back ready, captures the
//   product, and returns it with a one-cycle done pulse. A transaction that
//   has not completed within TIMEOUT-1 cycles after the start cycle is
//   aborted: done still pulses, err is flagged and the result reads zero.
//
//   State  | Meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no owner; arbitrate when the multiplier reports ready
//   START  | operands presented, mul_start high for this cycle only
//   BUSY   | waiting for the multiplier to drop mul_ready
//   WAIT   | multiplier working; waiting for mul_ready to return
//   RESP   | done (and err on abort) pulse; grant released on exit
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   req        in   4   request, bit i = requester i
//   req_a      in  16   operand A, requester i on [4i+3:4i]
//   req_b      in  16   operand B, same packing as req_a
//   gnt        out  4   one-hot grant (current owner of the multiplier)
//   done       out  4   one-cycle completion pulse for the owner
//   err        out  1   abort flag, coincident with done
//   res        out  9   result for the requester flagged by done
//   mul_a      out  4   operand A to the multiplier
//   mul_b      out  4   operand B to the multiplier
//   mul_start  out  1   start pulse to the multiplier
//   mul_ready  in   1   multiplier idle / result valid
//   mul_result in   9   multiplier product
// ---------------------------------------------------------------------------
module mul_arbiter #(
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic        err,
    output logic [8:0]  res,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    output logic        mul_start,
    input  logic        mul_ready,
    input  logic [8:0]  mul_result
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BUSY  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [1:0]     idx_q, idx_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [3:0]     gnt_q, gnt_d;
    logic [3:0]     done_q, done_d;
    logic           err_q, err_d;
    logic [8:0]     res_q, res_d;
    logic [3:0]     mul_a_q, mul_a_d;
    logic [3:0]     mul_b_q, mul_b_d;
    logic           mul_start_q, mul_start_d;

    logic           win_vld;
    logic [1:0]     win_idx;
    logic [1:0]     cand;
    logic [TW-1:0]  timer_inc;
    logic           timeout_hit;
    logic [3:0]     owner_onehot;

    // Round-robin search starting at ptr. The loop walks offsets from the
    // farthest to the nearest so the nearest requesting index wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        cand    = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // The timer counts cycles since leaving START; the abort fires on the
    // edge where its incremented value reaches TIMEOUT-1, so done lands
    // exactly TIMEOUT-1 cycles after the START exit.
    assign timer_inc    = timer_q + TW'(1);
    assign timeout_hit  = (timer_inc == TW'(TIMEOUT - 1));
    assign owner_onehot = 4'b0001 << idx_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        gnt_d       = gnt_q;
        done_d      = 4'b0000;
        err_d       = 1'b0;
        res_d       = res_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_start_d = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (win_vld && mul_ready) begin
                    idx_d       = win_idx;
                    gnt_d       = 4'b0001 << win_idx;
                    mul_a_d     = req_a[{win_idx, 2'b00} +: 4];
                    mul_b_d     = req_b[{win_idx, 2'b00} +: 4];
                    mul_start_d = 1'b1;
                    state_d     = START;
                end
            end

            START: begin
                timer_d = '0;
                state_d = BUSY;
            end

            BUSY: begin
                timer_d = timer_inc;
                if (timeout_hit) begin
                    done_d  = owner_onehot;
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = RESP;
                end else if (!mul_ready) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                timer_d = timer_inc;
                // A valid product in hand beats an abort on the same cycle.
                if (mul_ready) begin
                    done_d  = owner_onehot;
                    res_d   = mul_result;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    done_d  = owner_onehot;
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = RESP;
                end
            end

            RESP: begin
                gnt_d   = 4'b0000;
                ptr_d   = idx_q + 2'd1;
                state_d = IDLE;
            end

            default: begin
                gnt_d   = 4'b0000;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            idx_q       <= 2'd0;
            timer_q     <= '0;
            gnt_q       <= 4'b0000;
            done_q      <= 4'b0000;
            err_q       <= 1'b0;
            res_q       <= 9'd0;
            mul_a_q     <= 4'd0;
            mul_b_q     <= 4'd0;
            mul_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            res_q       <= res_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_start_q <= mul_start_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign res       = res_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_start = mul_start_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mul_arbiter
//   Directed bench for mul_arbiter with a small multiplier model: on a start
//   pulse the model drops ready for two cycles, then returns ready with the
//   product of the registered operands. hold_ready keeps the model ready
//   (never goes busy) to force an abort; force_busy masks ready low.
// ---------------------------------------------------------------------------
module tb_mul_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [15:0] req_a = 16'h0000;
    logic [15:0] req_b = 16'h0000;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        err;
    logic [8:0]  res;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic        mul_start;
    logic        mul_ready;
    logic [8:0]  mul_result;

    logic        rdy_q;
    logic [1:0]  lat_cnt;
    logic        hold_ready = 1'b0;
    logic        force_busy = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int viol  = 0;
    int lat;
    int starts;
    int seen;
    logic [3:0] g;

    always #5 clk = ~clk;

    mul_arbiter #(.TIMEOUT(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .res        (res),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_start  (mul_start),
        .mul_ready  (mul_ready),
        .mul_result (mul_result)
    );

    assign mul_ready = rdy_q & ~force_busy;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q      <= 1'b1;
            lat_cnt    <= 2'd0;
            mul_result <= 9'd0;
        end else if (mul_start && !hold_ready) begin
            rdy_q   <= 1'b0;
            lat_cnt <= 2'd2;
        end else if (lat_cnt == 2'd1) begin
            rdy_q      <= 1'b1;
            mul_result <= 9'(mul_a) * 9'(mul_b);
            lat_cnt    <= 2'd0;
        end else if (lat_cnt > 2'd1) begin
            lat_cnt <= lat_cnt - 2'd1;
        end
    end

    always @(negedge clk) begin
        if (!reset && (!$onehot0(gnt) || !$onehot0(done)))
            viol <= viol + 1;
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[4*i +: 4] = a;
        req_b[4*i +: 4] = b;
    endtask

    task automatic wait_gnt(output logic [3:0] gg);
        bit got;
        got = 1'b0;
        gg  = 4'b0000;
        for (int n = 0; n < 50 && !got; n++) begin
            tick();
            if (gnt != 4'b0000) begin
                got = 1'b1;
                gg  = gnt;
            end
        end
        if (!got) chk_val("wait_gnt_bound", 32'd0, 32'd1);
    endtask

    task automatic wait_done(output logic [3:0] d, output logic [3:0] gg, output logic e,
                             output logic [8:0] r, output int lt, output int st);
        int  g_at;
        bit  got;
        g_at = -1;
        got  = 1'b0;
        d    = 4'b0000;
        gg   = 4'b0000;
        e    = 1'b0;
        r    = 9'd0;
        lt   = -1;
        st   = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            tick();
            if (mul_start) st++;
            if (gnt != 4'b0000 && g_at < 0) g_at = n;
            if (done != 4'b0000) begin
                got = 1'b1;
                d   = done;
                gg  = gnt;
                e   = err;
                r   = res;
                lt  = n - g_at;
            end
        end
        if (!got) chk_val("wait_done_bound", 32'd0, 32'd1);
    endtask

    task automatic serve(input string tag, input logic [3:0] exp_d, input logic [8:0] exp_r,
                         input logic exp_e, output int lt, output int st);
        logic [3:0] d;
        logic [3:0] gg;
        logic       e;
        logic [8:0] r;
        wait_done(d, gg, e, r, lt, st);
        chk_val({tag, "_done"}, 32'(d),  32'(exp_d));
        chk_val({tag, "_gnt"},  32'(gg), 32'(exp_d));
        chk_val({tag, "_res"},  32'(r),  32'(exp_r));
        chk_val({tag, "_err"},  32'(e),  32'(exp_e));
        req = req & ~d;
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        chk_val("rst_gnt",   32'(gnt),       32'd0);
        chk_val("rst_done",  32'(done),      32'd0);
        chk_val("rst_err",   32'(err),       32'd0);
        chk_val("rst_res",   32'(res),       32'd0);
        chk_val("rst_mul_a", 32'(mul_a),     32'd0);
        chk_val("rst_mul_b", 32'(mul_b),     32'd0);
        chk_val("rst_start", 32'(mul_start), 32'd0);
        reset = 1'b0;
        tick();

        // All four at once: served 0,1,2,3
        set_op(0, 4'd2, 4'd3);
        set_op(1, 4'd4, 4'd5);
        set_op(2, 4'd6, 4'd7);
        set_op(3, 4'd15, 4'd15);
        req = 4'b1111;
        serve("all_r0", 4'b0001, 9'd6,   1'b0, lat, starts);
        serve("all_r1", 4'b0010, 9'd20,  1'b0, lat, starts);
        serve("all_r2", 4'b0100, 9'd42,  1'b0, lat, starts);
        serve("all_r3", 4'b1000, 9'd225, 1'b0, lat, starts);

        // Pointer back at 0: requester 1 ahead of 3
        set_op(1, 4'd11, 4'd9);
        set_op(3, 4'd1,  4'd2);
        req = 4'b1010;
        serve("wrap_r1", 4'b0010, 9'd99, 1'b0, lat, starts);
        serve("wrap_r3", 4'b1000, 9'd2,  1'b0, lat, starts);

        // Single request, latency and start-pulse count
        set_op(0, 4'd11, 4'd9);
        req = 4'b0001;
        serve("single", 4'b0001, 9'd99, 1'b0, lat, starts);
        chk_val("single_lat",    32'(lat),    32'd4);
        chk_val("single_starts", 32'(starts), 32'd1);
        tick();
        chk_val("single_done_pulse", 32'(done),  32'd0);
        chk_val("single_gnt_clear",  32'(gnt),   32'd0);
        chk_val("single_mul_a_hold", 32'(mul_a), 32'd11);

        // Multiplier not ready in IDLE: nothing granted
        force_busy = 1'b1;
        set_op(2, 4'd3, 4'd3);
        req = 4'b0100;
        seen = 0;
        repeat (6) begin
            tick();
            if (gnt != 4'b0000 || mul_start) seen++;
        end
        chk_val("busy_no_gnt", 32'(seen), 32'd0);
        force_busy = 1'b0;
        serve("busy_r2", 4'b0100, 9'd9, 1'b0, lat, starts);

        // ptr=3 after requester 2: 0 goes before 2
        set_op(0, 4'd2, 4'd7);
        set_op(2, 4'd5, 4'd5);
        req = 4'b0101;
        serve("rr_r0", 4'b0001, 9'd14, 1'b0, lat, starts);
        serve("rr_r2", 4'b0100, 9'd25, 1'b0, lat, starts);

        // Abort: multiplier never goes busy
        hold_ready = 1'b1;
        set_op(3, 4'd3, 4'd4);
        req = 4'b1000;
        serve("tmo", 4'b1000, 9'd0, 1'b1, lat, starts);
        chk_val("tmo_lat", 32'(lat), 32'd32);
        hold_ready = 1'b0;
        tick();
        chk_val("tmo_err_pulse", 32'(err), 32'd0);
        set_op(1, 4'd5, 4'd6);
        req = 4'b0010;
        serve("after_tmo", 4'b0010, 9'd30, 1'b0, lat, starts);

        // Reset while in WAIT (ptr=2 beforehand)
        set_op(2, 4'd7, 4'd7);
        req = 4'b0100;
        wait_gnt(g);
        chk_val("rstw_gnt", 32'(g), 32'b0100);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk_val("rstw_gnt0",   32'(gnt),       32'd0);
        chk_val("rstw_done0",  32'(done),      32'd0);
        chk_val("rstw_err0",   32'(err),       32'd0);
        chk_val("rstw_res0",   32'(res),       32'd0);
        chk_val("rstw_mul_a0", 32'(mul_a),     32'd0);
        chk_val("rstw_mul_b0", 32'(mul_b),     32'd0);
        chk_val("rstw_start0", 32'(mul_start), 32'd0);
        req = 4'b0000;
        seen = 0;
        repeat (2) begin
            tick();
            if (done != 4'b0000) seen++;
        end
        reset = 1'b0;
        tick();
        if (done != 4'b0000) seen++;
        chk_val("rstw_no_done", 32'(seen), 32'd0);
        set_op(1, 4'd11, 4'd9);
        set_op(3, 4'd1,  4'd2);
        req = 4'b1010;
        serve("post_rst_r1", 4'b0010, 9'd99, 1'b0, lat, starts);
        serve("post_rst_r3", 4'b1000, 9'd2,  1'b0, lat, starts);

        // Operands changed after grant are ignored
        set_op(0, 4'd15, 4'd15);
        req = 4'b0001;
        wait_gnt(g);
        chk_val("opchg_gnt", 32'(g), 32'b0001);
        set_op(0, 4'd1, 4'd1);
        serve("opchg", 4'b0001, 9'd225, 1'b0, lat, starts);
        chk_val("opchg_mul_a", 32'(mul_a), 32'd15);
        chk_val("opchg_mul_b", 32'(mul_b), 32'd15);

        tick();
        chk_val("onehot", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 32, max cycles from START exit until abort of a transaction.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  request, bit i = requester i.
REQ-005 req_a  input  16  operand A, requester i on bits [4i+3:4i].
REQ-006 req_b  input  16  operand B, same packing as req_a.
REQ-007 gnt  output  4  one-hot grant; requester currently owning the multiplier.
REQ-008 done  output  4  one-cycle completion pulse, bit i = requester i.
REQ-009 err  output  1  one-cycle pulse coincident with done when transaction aborted by timeout.
REQ-010 res  output  9  result for requester flagged by done; held until next done.
REQ-011 mul_a  output  4  operand A to shared multiplier (registered).
REQ-012 mul_b  output  4  operand B to shared multiplier (registered).
REQ-013 mul_start  output  1  start pulse to multiplier.
REQ-014 mul_ready  input  1  multiplier idle / result valid.
REQ-015 mul_result  input  9  multiplier product.

Function
REQ-016 FSM states SHALL be IDLE, START, BUSY, WAIT, RESP; all outputs registered.
REQ-017 IDLE: if req!=0 and mul_ready=1, select winner, latch index, set gnt one-hot, latch winner operands into mul_a/mul_b, go START; else stay, gnt=0.
REQ-018 IDLE with mul_ready=0 SHALL grant nothing regardless of req.
REQ-019 Arbitration SHALL be round-robin: search order ptr, ptr+1, ..., wrapping 3->0; ptr resets to 0.
REQ-020 START: mul_start=1 for exactly this one cycle; timer cleared; go BUSY.
REQ-021 BUSY: timer increments each cycle; mul_ready=0 -> WAIT.
REQ-022 WAIT: timer increments; mul_ready=1 -> capture mul_result into res unmodified (9 bits), go RESP.
REQ-023 Timeout: timer reaching TIMEOUT-1 in BUSY or WAIT -> go RESP with err flagged, res=0.
REQ-024 RESP: done[idx]=1 (and err if flagged) for one cycle; gnt held through RESP, cleared on exit; ptr=(idx+1) mod 4; go IDLE.
REQ-025 Minimum transaction: IDLE->START->BUSY->WAIT->RESP, done no earlier than 4 cycles after grant.
REQ-026 Operands SHALL be sampled only on IDLE->START; later req_a/req_b changes have no effect.
REQ-027 Requester holds req and operands until done; deasserts req at the edge where it samples done=1; req still high in following IDLE = new request.
REQ-028 req dropped before grant: not served; req dropped after grant: transaction completes, done still pulses.
REQ-029 mul_start SHALL never assert outside START; mul_a/mul_b hold latched values until next grant.
REQ-030 At most one bit of gnt and done SHALL be set at any time.

Reset
REQ-031 reset=1 SHALL immediately force state IDLE, gnt=0, done=0, err=0, res=0, mul_a=0, mul_b=0, mul_start=0, ptr=0, timer=0.
REQ-032 Reset mid-transaction SHALL abort it with no done pulse; first grant after release follows ptr=0.

Verification
REQ-033 req=0001, a0=11, b0=9, model multiplier -> gnt=0001, one mul_start pulse, done=0001, res=99, err=0.
REQ-034 req=1111 simultaneous, operands (2,3),(4,5),(6,7),(15,15) -> done order 0,1,2,3, res 6,20,42,225, ptr returns 0.
REQ-035 After serving requester 2 (ptr=3), req=0101 -> requester 0 served first, then 2.
REQ-036 Model holds mul_ready=1 after start -> done with err=1, res=0 exactly TIMEOUT-1 cycles after START exit; next request completes normally.
REQ-037 reset asserted during WAIT -> all outputs 0 same cycle, no done; after release req=0010 (a=11,b=9) -> res=99.
REQ-038 Operands changed to (1,1) after grant on (15,15) -> res=225.
